delay_pattern_gen: RTL and testbench
====================================

Name: delay_pattern_gen

Overview:
- Upstream stimulus source for the N-bit register delay stage; drives its idata bus with a deterministic burst of test words.
- Produces a qualifying valid strobe, so the downstream bench or checker can align delayed output against generated input.
- Burst is started and stopped by control inputs; pattern type is selectable (counter, walking-one, LFSR, constant).

Parameters:
- N, 3, data width; must match the delay stage width; N >= 2.
- BURST_LEN, 16, number of words per burst; >= 1.
- TAPS, 3'b110 (N bits), Galois LFSR feedback mask; default is x^3+x^2+1 for N=3.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  burst request; sampled only in IDLE.
- stop  in  1  abort; sampled only in RUN.
- mode  in  2  pattern select; 0 counter, 1 walking-one, 2 LFSR, 3 constant.
- seed  in  N  initial value; sampled together with start.
- odata  out  N  pattern word; connects to the delay stage data input.
- ovalid  out  1  odata holds a burst word this cycle.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse after a burst completes normally.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst_n=0 at a clk edge): state IDLE, odata=0, ovalid=0, busy=0, done=0, word counter=0. Reset wins over every other input, including mid-burst.
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 at an edge latches mode and seed. Next cycle: state RUN, ovalid=1, busy=1, odata = first word. stop is ignored in IDLE; start+stop together = start.
- First word by mode:
  - counter: seed.
  - walking-one: 1 (seed ignored).
  - LFSR: seed, or 1 if seed==0.
  - constant: seed.
- RUN: each cycle advances odata to the next word and increments the word counter.
  - counter: +1 mod 2^N (2^N-1 wraps to 0).
  - walking-one: rotate left; MSB wraps to bit 0.
  - LFSR: next = (s>>1) ^ (s[0] ? TAPS : 0).
  - constant: odata unchanged.
- Burst completion: after exactly BURST_LEN valid cycles, next state is DONE, with ovalid=0, busy=0, done=1 for one cycle. Then IDLE unconditionally. start is ignored in DONE.
- stop=1 in RUN: next cycle IDLE, ovalid=0, busy=0, done stays 0 (aborted burst gives no done). stop on the final word cycle also aborts, with no done.
- mode/seed changes during RUN are ignored; only the values latched at start are used.
- odata holds the last emitted word when ovalid=0 after a burst or abort. Consumers must qualify odata with ovalid.
- Word counter width: $clog2(BURST_LEN+1); it never wraps within a burst.
- Latency: start edge to first valid word = 1 cycle. Back-to-back bursts: minimum gap of 2 idle cycles (DONE, then IDLE sampling start).

Optional Feature:
- Macro: PATGEN_CONT_EN.
- Defined: adds input port cont (1 bit), latched at start. If the latched cont=1, RUN never exits on BURST_LEN; the counter saturates at BURST_LEN; only stop or reset leave RUN, and done is never asserted for that burst. Latched cont=0 behaves as without the macro.
- Undefined: no cont port; every burst terminates after BURST_LEN words.

Test Plan:
- Reset mid-burst: N=3, mode=0, seed=3'd6, start at cycle 0; rst_n=0 at word 3 -> next cycle odata=0, ovalid=0, busy=0, state IDLE; a later start restarts cleanly from seed.
- Counter with wrap: N=3, BURST_LEN=16, mode=0, seed=3'd6 -> odata 6,7,0,1,... for 16 valid cycles; ovalid=1 exactly 16 cycles; done=1 on the 17th cycle; busy back to 0.
- LFSR sequence: mode=2, seed=0 -> 1,6,3,7,5,4,2,1,... (period 7, zero never emitted); a second run with seed=3'd5 gives 5,4,2,1,6,...
- Walking-one with abort: mode=1, seed=3'd7; stop asserted while the 3rd word is shown -> words 1,2,4; ovalid low the next cycle; done never asserted.
- Control corner cases: start+stop together in IDLE -> burst starts; start pulsed during RUN and DONE -> ignored; seed changed mid-burst -> sequence unaffected; stop on the 16th word -> no done.
- Continuous mode (PATGEN_CONT_EN defined): cont=1, mode=3, seed=3'd5 -> odata=5 with ovalid=1 for 40 cycles, no done; stop -> IDLE. With cont=0, identical to the counter test.

Source files
------------

// File: rtl/delay_pattern_gen_if.sv
// =============================================================================
// Module  : delay_pattern_gen_if
// Brief   : Control/data bundle between the pattern generator and its consumer.
//           The cont signal exists only when PATGEN_CONT_EN is defined.
// Revision: 1.0
// =============================================================================
`default_nettype none

interface delay_pattern_gen_if #(
    parameter int N = 3
);
    logic         start;
    logic         stop;
    logic [1:0]   mode;
    logic [N-1:0] seed;
`ifdef PATGEN_CONT_EN
    logic         cont;
`endif
    logic [N-1:0] odata;
    logic         ovalid;
    logic         busy;
    logic         done;

`ifdef PATGEN_CONT_EN
    modport master (output start, stop, mode, seed, cont,
                    input  odata, ovalid, busy, done);
    modport slave  (input  start, stop, mode, seed, cont,
                    output odata, ovalid, busy, done);
`else
    modport master (output start, stop, mode, seed,
                    input  odata, ovalid, busy, done);
    modport slave  (input  start, stop, mode, seed,
                    output odata, ovalid, busy, done);
`endif
endinterface

`default_nettype wire

// File: rtl/delay_pattern_gen.sv
// =============================================================================
// Module  : delay_pattern_gen
// Brief   : Burst pattern source (counter / walking-one / LFSR / constant) with
//           valid strobe. Optional macro PATGEN_CONT_EN adds continuous bursts.
// Revision: 1.0
// =============================================================================
`default_nettype none

module delay_pattern_gen #(
    parameter int           N         = 3,
    parameter int           BURST_LEN = 16,
    parameter logic [N-1:0] TAPS      = 3'b110
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    delay_pattern_gen_if.slave   pg
);
    localparam int         CNT_W    = $clog2(BURST_LEN + 1);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;
    localparam logic [1:0] M_CNT    = 2'd0;
    localparam logic [1:0] M_WALK   = 2'd1;
    localparam logic [1:0] M_LFSR   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [N-1:0]     odata_q, odata_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [1:0]       mode_q,  mode_d;
    logic             cont_q,  cont_d;
    logic             w_last;
    logic             w_cont_in;
    logic [N-1:0]     w_first;
    logic [N-1:0]     w_next;

`ifdef PATGEN_CONT_EN
    assign w_cont_in = pg.cont;
`else
    assign w_cont_in = 1'b0;
`endif

    assign w_last = (cnt_q == CNT_W'(BURST_LEN));

    // First word depends on the live mode/seed since they are captured this edge
    always_comb begin
        w_first = pg.seed;
        case (pg.mode)
            M_WALK:  w_first = N'(1);
            M_LFSR:  w_first = (pg.seed == '0) ? N'(1) : pg.seed;
            default: w_first = pg.seed;
        endcase
    end

    always_comb begin
        w_next = odata_q;
        case (mode_q)
            M_CNT:   w_next = odata_q + N'(1);
            M_WALK:  w_next = {odata_q[N-2:0], odata_q[N-1]};
            M_LFSR:  w_next = (odata_q >> 1) ^ (odata_q[0] ? TAPS : '0);
            default: w_next = odata_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            odata_q <= '0;
            cnt_q   <= '0;
            mode_q  <= M_CNT;
            cont_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            odata_q <= odata_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            cont_q  <= cont_d;
        end
    end

    always_comb begin
        state_d = state_q;
        odata_d = odata_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        cont_d  = cont_q;
        case (state_q)
            S_IDLE: begin
                if (pg.start) begin
                    state_d = S_RUN;
                    odata_d = w_first;
                    cnt_d   = CNT_W'(1);
                    mode_d  = pg.mode;
                    cont_d  = w_cont_in;
                end
            end
            S_RUN: begin
                if (pg.stop) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (w_last && !cont_q) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    // Counter saturates in continuous mode; pattern keeps advancing
                    odata_d = w_next;
                    cnt_d   = w_last ? cnt_q : cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        pg.odata  = odata_q;
        pg.ovalid = (state_q == S_RUN);
        pg.busy   = (state_q == S_RUN);
        pg.done   = (state_q == S_DONE);
    end

endmodule

`default_nettype wire

// File: tb/tb_delay_pattern_gen.sv
// =============================================================================
// Module  : tb_delay_pattern_gen
// Brief   : Directed plus randomized stimulus against a word-index reference model.
// Revision: 1.0
// =============================================================================
`default_nettype none

module tb_delay_pattern_gen;
    localparam int           N    = 3;
    localparam int           BL   = 16;
    localparam logic [N-1:0] TAPS = 3'b110;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    logic cont_v;

    delay_pattern_gen_if #(.N(N)) pg ();

    delay_pattern_gen #(
        .N         (N),
        .BURST_LEN (BL),
        .TAPS      (TAPS)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pg    (pg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: burst position k plus the latched configuration
    logic         m_act;
    logic         m_done;
    int           m_k;
    logic [1:0]   m_mode;
    logic [N-1:0] m_seed;
    logic         m_cont;
    logic [N-1:0] m_out;

    function automatic logic [N-1:0] word_at(input logic [1:0] md, input logic [N-1:0] sd, input int k);
        logic [N-1:0] s;
        case (md)
            2'd0:    return N'(int'(sd) + k);
            2'd1:    return N'(1 << (k % N));
            2'd2: begin
                s = (sd == '0) ? N'(1) : sd;
                for (int i = 0; i < k; i++) s = (s >> 1) ^ (s[0] ? TAPS : '0);
                return s;
            end
            default: return sd;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic rn, input logic st, input logic sp,
                              input logic [1:0] md, input logic [N-1:0] sd, input logic c);
        if (!rn) begin
            m_act  = 1'b0;
            m_done = 1'b0;
            m_out  = '0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_act) begin
            if (sp) begin
                m_act = 1'b0;
            end else if ((m_k + 1 >= BL) && !m_cont) begin
                m_act  = 1'b0;
                m_done = 1'b1;
            end else begin
                m_k++;
                m_out = word_at(m_mode, m_seed, m_k);
            end
        end else if (st) begin
            m_act  = 1'b1;
            m_k    = 0;
            m_mode = md;
            m_seed = sd;
            m_cont = c;
            m_out  = word_at(md, sd, 0);
        end
    endtask

    task automatic cyc(input logic rn, input logic st, input logic sp,
                       input logic [1:0] md, input logic [N-1:0] sd);
        logic c;
        rst_n    = rn;
        pg.start = st;
        pg.stop  = sp;
        pg.mode  = md;
        pg.seed  = sd;
`ifdef PATGEN_CONT_EN
        pg.cont  = cont_v;
        c        = cont_v;
`else
        c        = 1'b0;
`endif
        @(posedge clk);
        model_step(rn, st, sp, md, sd, c);
        #1;
        check("odata",  32'(pg.odata),  32'(m_out));
        check("ovalid", 32'(pg.ovalid), 32'(m_act));
        check("busy",   32'(pg.busy),   32'(m_act));
        check("done",   32'(pg.done),   32'(m_done));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 2'd0, 3'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cont_v   = 1'b0;
        m_act = 1'b0; m_done = 1'b0; m_k = 0; m_mode = 2'd0;
        m_seed = '0; m_cont = 1'b0; m_out = '0;
        rst_n = 1'b0; pg.start = 1'b0; pg.stop = 1'b0; pg.mode = 2'd0; pg.seed = '0;
`ifdef PATGEN_CONT_EN
        pg.cont = 1'b0;
`endif
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 2'd0, 3'd0);

        // Counter with wrap, full burst and done
        cyc(1'b1, 1'b1, 1'b0, 2'd0, 3'd6);
        idle(20);
        // Reset mid-burst then clean restart
        cyc(1'b1, 1'b1, 1'b0, 2'd0, 3'd6);
        idle(2);
        cyc(1'b0, 1'b0, 1'b0, 2'd0, 3'd0);
        idle(2);
        cyc(1'b1, 1'b1, 1'b0, 2'd0, 3'd6);
        idle(19);
        // LFSR from zero seed, then seed 5
        cyc(1'b1, 1'b1, 1'b0, 2'd2, 3'd0);
        idle(18);
        cyc(1'b1, 1'b1, 1'b0, 2'd2, 3'd5);
        idle(18);
        // Walking-one aborted while the third word is shown
        cyc(1'b1, 1'b1, 1'b0, 2'd1, 3'd7);
        idle(2);
        cyc(1'b1, 1'b0, 1'b1, 2'd1, 3'd7);
        idle(3);
        // start+stop together starts; start during RUN/DONE ignored; seed churn
        cyc(1'b1, 1'b1, 1'b1, 2'd0, 3'd2);
        for (int i = 0; i < 17; i++) cyc(1'b1, 1'b1, 1'b0, 2'(i), 3'(i));
        idle(2);
        // Stop on the final word gives no done
        cyc(1'b1, 1'b1, 1'b0, 2'd0, 3'd1);
        idle(BL - 1);
        cyc(1'b1, 1'b0, 1'b1, 2'd0, 3'd0);
        idle(3);
`ifdef PATGEN_CONT_EN
        cont_v = 1'b1;
        cyc(1'b1, 1'b1, 1'b0, 2'd3, 3'd5);
        cont_v = 1'b0;
        idle(40);
        cyc(1'b1, 1'b0, 1'b1, 2'd3, 3'd0);
        idle(2);
        cyc(1'b1, 1'b1, 1'b0, 2'd0, 3'd6);
        idle(19);
`endif
        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
`ifdef PATGEN_CONT_EN
            cont_v = ($urandom % 8) == 0;
`endif
            cyc(($urandom % 100) != 0, ($urandom % 4) == 0, ($urandom % 24) == 0,
                2'($urandom), 3'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
